// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//
// Turns single-cycle event strobes into long, human-visible high levels. Each
// accepted event gives one HIGH_CYCLES-long burst followed by at least
// GAP_CYCLES of low time. Events that arrive during a burst or gap are counted
// in a saturating pending counter and replayed back-to-back.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   pulse_in   : event strobe, every high cycle is one event
//   level_out  : stretched output (high while in HIGH), registered
//   busy       : high whenever not IDLE, registered
//   pending    : queued bursts not yet started
//   overflow   : one-cycle strobe, an event was dropped on the previous cycle
//
// Handshake: there is no back-pressure. pulse_in is sampled on every rising
// edge; an event that finds the pending counter full is dropped and reported
// on overflow one cycle later.
//
// The FSM state is held in state_q (type state_t) for hierarchical probing.
// -----------------------------------------------------------------------------
module pulse_stretcher #(
  parameter int COUNT_BITS  = 16,
  parameter int HIGH_CYCLES = 50000,
  parameter int GAP_CYCLES  = 50000,
  parameter int QUEUE_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pulse_in,
  output logic                  level_out,
  output logic                  busy,
  output logic [QUEUE_BITS-1:0] pending,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counters hold "cycles remaining minus one", so a duration of 2^COUNT_BITS
  // still fits in COUNT_BITS bits.
  localparam logic [COUNT_BITS-1:0] HIGH_LOAD = COUNT_BITS'(HIGH_CYCLES - 1);
  localparam logic [COUNT_BITS-1:0] GAP_LOAD  = COUNT_BITS'(GAP_CYCLES - 1);
  localparam logic [QUEUE_BITS-1:0] PEND_MAX  = '1;

  state_t                  state_q, state_d;
  logic [COUNT_BITS-1:0]   cnt_q, cnt_d;
  logic [QUEUE_BITS-1:0]   pend_q, pend_d;
  logic                    enq;
  logic                    drop;
  logic                    level_q, level_d;
  logic                    busy_q, busy_d;
  logic                    ovf_q;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      ovf_q   <= drop;
    end
  end

  // Next-state, counter and pending-queue logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    enq     = 1'b0;
    drop    = 1'b0;

    case (state_q)
      IDLE: begin
        // Event consumed directly; the queue is never touched from IDLE.
        if (pulse_in) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end

      HIGH: begin
        enq = pulse_in;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - COUNT_BITS'(1);
        end
      end

      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - COUNT_BITS'(1);
          enq   = pulse_in;
        end else if ((pend_q != '0) || pulse_in) begin
          // Last gap cycle: start the next burst with no idle cycle. A pulse
          // arriving now either is consumed directly (queue empty) or
          // replaces the queued event being consumed (queue unchanged).
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
          if ((pend_q != '0) && !pulse_in) begin
            pend_d = pend_q - QUEUE_BITS'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase

    // Saturating enqueue: a full queue holds its value and drops the event.
    if (enq) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + QUEUE_BITS'(1);
      end
    end
  end

  // Output decode from the next state so the outputs come straight from flops.
  always_comb begin
    level_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
//
// Directed bench with HIGH_CYCLES=4, GAP_CYCLES=2, QUEUE_BITS=2. Each scenario
// is a table: bit c of the pulse vector is driven during cycle c, and bit c of
// the level/busy/overflow vectors (plus entry c of the pending queue) is the
// value expected during cycle c. Cycle c's outputs are sampled at the falling
// edge in the middle of the cycle, and the pulse for cycle c is driven there
// too, so it is captured by the rising edge that ends cycle c.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

  localparam int QB = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pulse_in = 1'b0;
  logic          level_out;
  logic          busy;
  logic [QB-1:0] pending;
  logic          overflow;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .COUNT_BITS (16),
    .HIGH_CYCLES(4),
    .GAP_CYCLES (2),
    .QUEUE_BITS (QB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .level_out(level_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_fails  = 0;
  logic [QB-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic lvl, input logic bsy,
                           input logic ovf, input logic [QB-1:0] pnd);
    check($sformatf("%s level", tag),    32'(level_out), 32'(lvl));
    check($sformatf("%s busy", tag),     32'(busy),      32'(bsy));
    check($sformatf("%s overflow", tag), 32'(overflow),  32'(ovf));
    check($sformatf("%s pending", tag),  32'(pending),   32'(pnd));
  endtask

  // ---------------- driver ----------------
  // Expected pending values come from exp_q (one per cycle, 0 once empty).
  task automatic run_scn(input string name, input int n, input logic [31:0] pul,
                         input logic [31:0] lvl, input logic [31:0] bsy,
                         input logic [31:0] ovf);
    logic [QB-1:0] pnd;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      pnd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check_all($sformatf("%s c%0d", name, c), lvl[c], bsy[c], ovf[c], pnd);
      pulse_in = pul[c];
    end
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values: pulse_in toggling while reset is held.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_all($sformatf("in_reset c%0d", c), 1'b0, 1'b0, 1'b0, '0);
      pulse_in = ~pulse_in;
    end
    @(negedge clk);
    pulse_in = 1'b0;
    rst_n    = 1'b1;
    run_scn("post_reset", 4, 32'h0, 32'h0, 32'h0, 32'h0);

    // Single pulse: level t+1..t+4, busy t+1..t+6.
    run_scn("single", 10, 32'h1, 32'h1E, 32'h7E, 32'h0);

    // Queued pulses at t, t+1, t+2.
    exp_q = '{0,0,1,2,2,2,2, 1,1,1,1,1,1, 0,0,0,0,0,0,0,0};
    run_scn("queued", 21, 32'h7, 32'h0001_E79E, 32'h0007_FFFE, 32'h0);

    // Overflow: pulses t..t+4, the last one is dropped.
    exp_q = '{0,0,1,2,3,3,3, 2,2,2,2,2,2, 1,1,1,1,1,1, 0,0,0,0,0,0,0,0};
    run_scn("overflow", 27, 32'h1F, 32'h0079_E79E, 32'h01FF_FFFE, 32'h20);

    // Second pulse in the last gap cycle: no idle cycle, queue untouched.
    run_scn("last_gap", 15, 32'h41, 32'h79E, 32'h1FFE, 32'h0);

    // Reset mid-operation: pulses t..t+2, reset asserted inside cycle t+3.
    exp_q = '{0,0,1};
    run_scn("mid_reset", 3, 32'h7, 32'h6, 32'h6, 32'h0);
    @(posedge clk);
    #1 pulse_in = 1'b0;
    check_all("pre_abort", 1'b1, 1'b1, 1'b0, 2'd2);
    #1 rst_n = 1'b0;
    #1 check_all("async_abort", 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("abort_held", 1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    run_scn("after_abort", 20, 32'h0, 32'h0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
